// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 slave front-end issuing single-cycle register accesses.
// Optional idle-sclk watchdog enabled by defining SPI_CTRL_TIMEOUT_EN.
module spi_reg_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic              rw,
    output logic              valid,
    output logic [ADDR_W-1:0] addr_to_reg,
    output logic [DATA_W-1:0] data_to_reg,
    input  logic [DATA_W-1:0] data_in_reg,
    output logic              busy,
    output logic              frame_err
);

    localparam int CMD_BITS = 8;
    localparam int FRM_BITS = CMD_BITS + DATA_W;
    localparam int CNT_W    = $clog2(FRM_BITS + 1);

    typedef enum logic [2:0] {
        IDLE, CMD, RD_REQ, RD_WAIT, RD_LOAD, DATA, WR_REQ, DONE
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic sclk_d, cs_d;
    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CMD_BITS-1:0] cmd_sr, cmd_nx;
    logic [DATA_W-1:0]   tx;
    logic active, tmo, err_n;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign active = (state == CMD) || (state == DATA) ||
                    (state == RD_REQ) || (state == RD_WAIT) ||
                    (state == RD_LOAD);

`ifdef SPI_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (sclk_rise || sclk_fall || !active) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_W'(TIMEOUT_CYC)) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign tmo = active && (to_cnt == TO_W'(TIMEOUT_CYC));
`else
    assign tmo = 1'b0;
`endif

    assign cmd_nx = {cmd_sr[CMD_BITS-2:0], mosi_s};

    always_comb begin
        state_n = state;
        err_n   = 1'b0;
        if (active && cs_rise) begin
            state_n = IDLE;
            err_n   = 1'b1;
        end else if (tmo) begin
            state_n = DONE;
            err_n   = 1'b1;
        end else begin
            case (state)
                IDLE:    if (cs_fall) state_n = CMD;
                CMD: begin
                    if (sclk_rise && bit_cnt == CNT_W'(CMD_BITS - 1))
                        state_n = cmd_nx[CMD_BITS-1] ? DATA : RD_REQ;
                end
                RD_REQ:  state_n = RD_WAIT;
                RD_WAIT: state_n = RD_LOAD;
                RD_LOAD: state_n = DATA;
                DATA: begin
                    if (sclk_rise && bit_cnt == CNT_W'(FRM_BITS - 1))
                        state_n = rw ? WR_REQ : DONE;
                end
                // a cs rise seen during the write strobe ends the frame here
                WR_REQ:  state_n = cs_rise ? IDLE : DONE;
                DONE:    if (cs_rise) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            frame_err   <= 1'b0;
            bit_cnt     <= '0;
            cmd_sr      <= '0;
            tx          <= '0;
            miso        <= 1'b0;
            rw          <= 1'b0;
            addr_to_reg <= '0;
            data_to_reg <= '0;
        end else begin
            state     <= state_n;
            frame_err <= err_n;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        bit_cnt <= '0;
                        miso    <= 1'b0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        cmd_sr  <= cmd_nx;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(CMD_BITS - 1)) begin
                            rw          <= cmd_nx[CMD_BITS-1];
                            addr_to_reg <= cmd_nx[ADDR_W-1:0];
                        end
                    end
                end
                RD_LOAD: tx <= data_in_reg;
                DATA: begin
                    if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (rw)
                            data_to_reg <= {data_to_reg[DATA_W-2:0], mosi_s};
                    end
                    if (!rw && sclk_fall) begin
                        miso <= tx[DATA_W-1];
                        tx   <= {tx[DATA_W-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid   = (state == RD_REQ) || (state == WR_REQ);
    assign busy    = (state != IDLE);
    assign miso_oe = ~cs_s;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl with a small register block model.
// Timeout scenario runs only when SPI_CTRL_TIMEOUT_EN is defined.
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst, sclk, cs_n, mosi;
    logic       miso, miso_oe, rw, valid, busy, frame_err;
    logic [3:0] addr_to_reg;
    logic [7:0] data_to_reg, data_in_reg;

    logic [7:0] regs [16];
    int vcnt = 0, ecnt = 0;
    logic       lrw;
    logic [3:0] laddr;
    logic [7:0] ldata;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    spi_reg_ctrl #(
        .SYNC_STAGES(2),
        .ADDR_W(4),
        .DATA_W(8)
`ifdef SPI_CTRL_TIMEOUT_EN
        , .TIMEOUT_CYC(50)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .sclk(sclk),
        .cs_n(cs_n),
        .mosi(mosi),
        .miso(miso),
        .miso_oe(miso_oe),
        .rw(rw),
        .valid(valid),
        .addr_to_reg(addr_to_reg),
        .data_to_reg(data_to_reg),
        .data_in_reg(data_in_reg),
        .busy(busy),
        .frame_err(frame_err)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) regs[i] <= 8'(i + 1);
            data_in_reg <= 8'h00;
        end else if (valid) begin
            if (rw) regs[addr_to_reg] <= data_to_reg;
            else    data_in_reg <= regs[addr_to_reg];
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                vcnt++;
                lrw   = rw;
                laddr = addr_to_reg;
                ldata = data_to_reg;
            end
            if (frame_err) ecnt++;
        end
    end

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [15:0] w, input int n,
                            output logic [15:0] r);
        r = '0;
        for (int i = 0; i < n; i++) begin
            mosi = w[15-i];
            half();
            sclk = 1'b1;
            r = {r[14:0], miso};
            half();
            sclk = 1'b0;
        end
    endtask

    task automatic cs_down();
        cs_n = 1'b0;
    endtask

    task automatic cs_up();
        half();
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({valid, rw, busy, frame_err, miso, miso_oe} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctl got=%b want=000000",
                     {valid, rw, busy, frame_err, miso, miso_oe});
        end
        total++;
        if ({addr_to_reg, data_to_reg} !== 12'h000) begin
            bad++;
            $display("FAIL reset_bus got=%h want=000",
                     {addr_to_reg, data_to_reg});
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle busy=%b want=0", busy);
        end
    endtask

    task automatic test_write();
        int v0, e0;
        logic [15:0] r;
        v0 = vcnt; e0 = ecnt;
        cs_down();
        spi_bits(16'h81A5, 16, r);
        cs_up();
        total++;
        if (vcnt - v0 !== 1) begin
            bad++;
            $display("FAIL wr_valid count=%0d want=1", vcnt - v0);
        end
        total++;
        if ({lrw, laddr, ldata} !== {1'b1, 4'h1, 8'hA5}) begin
            bad++;
            $display("FAIL wr_access rw=%b addr=%h data=%h want 1/1/a5",
                     lrw, laddr, ldata);
        end
        total++;
        if (ecnt - e0 !== 0) begin
            bad++;
            $display("FAIL wr_err count=%0d want=0", ecnt - e0);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL wr_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_read();
        int v0, e0;
        logic [15:0] r;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        v0 = vcnt; e0 = ecnt;
        cs_down();
        repeat (4) @(negedge clk);
        total++;
        if (miso_oe !== 1'b1) begin
            bad++;
            $display("FAIL rd_oe got=%b want=1", miso_oe);
        end
        spi_bits(16'h0200, 16, r);
        cs_up();
        total++;
        if (vcnt - v0 !== 1 || lrw !== 1'b0 || laddr !== 4'h2) begin
            bad++;
            $display("FAIL rd_access cnt=%0d rw=%b addr=%h want 1/0/2",
                     vcnt - v0, lrw, laddr);
        end
        total++;
        if (r !== 16'h0003) begin
            bad++;
            $display("FAIL rd_miso got=%h want=0003", r);
        end
        total++;
        if (ecnt - e0 !== 0 || miso_oe !== 1'b0) begin
            bad++;
            $display("FAIL rd_end err=%0d oe=%b want 0/0",
                     ecnt - e0, miso_oe);
        end
    endtask

    task automatic test_back_to_back();
        int v0;
        logic [15:0] r;
        v0 = vcnt;
        cs_down();
        spi_bits(16'hF03C, 16, r);
        cs_up();
        total++;
        if ({lrw, laddr, ldata} !== {1'b1, 4'h0, 8'h3C}) begin
            bad++;
            $display("FAIL b2b_wr rw=%b addr=%h data=%h want 1/0/3c",
                     lrw, laddr, ldata);
        end
        cs_down();
        spi_bits(16'h7000, 16, r);
        cs_up();
        total++;
        if (vcnt - v0 !== 2 || lrw !== 1'b0 || laddr !== 4'h0) begin
            bad++;
            $display("FAIL b2b_rd cnt=%0d rw=%b addr=%h want 2/0/0",
                     vcnt - v0, lrw, laddr);
        end
        total++;
        if (r !== 16'h003C) begin
            bad++;
            $display("FAIL b2b_miso got=%h want=003c", r);
        end
    endtask

    task automatic test_abort();
        int v0, e0;
        logic [15:0] r;
        v0 = vcnt; e0 = ecnt;
        cs_down();
        spi_bits(16'h8377, 10, r);
        cs_up();
        total++;
        if (ecnt - e0 !== 1) begin
            bad++;
            $display("FAIL abort_err count=%0d want=1", ecnt - e0);
        end
        total++;
        if (vcnt - v0 !== 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_state valid=%0d busy=%b want 0/0",
                     vcnt - v0, busy);
        end
        total++;
        if (regs[3] !== 8'h04) begin
            bad++;
            $display("FAIL abort_reg got=%h want=04", regs[3]);
        end
    endtask

    task automatic test_mid_reset();
        int v0;
        logic [15:0] r;
        cs_down();
        spi_bits(16'h81FF, 12, r);
        rst = 1'b1;
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({valid, rw, busy, frame_err, miso, miso_oe,
             addr_to_reg, data_to_reg} !== 18'h0) begin
            bad++;
            $display("FAIL mrst_outs got=%h want=0",
                     {valid, rw, busy, frame_err, miso, miso_oe,
                      addr_to_reg, data_to_reg});
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        v0 = vcnt;
        cs_down();
        spi_bits(16'h8111, 16, r);
        cs_up();
        total++;
        if (vcnt - v0 !== 1 || {lrw, laddr, ldata} !== {1'b1, 4'h1, 8'h11})
        begin
            bad++;
            $display("FAIL mrst_wr cnt=%0d rw=%b addr=%h data=%h want 1/1/1/11",
                     vcnt - v0, lrw, laddr, ldata);
        end
    endtask

`ifdef SPI_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int v0, e0;
        logic [15:0] r;
        v0 = vcnt; e0 = ecnt;
        cs_down();
        spi_bits(16'h8155, 4, r);
        repeat (60) @(negedge clk);
        total++;
        if (ecnt - e0 !== 1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL tmo_err err=%0d busy=%b want 1/1", ecnt - e0, busy);
        end
        spi_bits(16'hFFFF, 10, r);
        half();
        total++;
        if (vcnt - v0 !== 0 || ecnt - e0 !== 1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL tmo_dead valid=%0d err=%0d busy=%b want 0/1/1",
                     vcnt - v0, ecnt - e0, busy);
        end
        cs_up();
        total++;
        if (busy !== 1'b0 || ecnt - e0 !== 1) begin
            bad++;
            $display("FAIL tmo_end busy=%b err=%0d want 0/1", busy, ecnt - e0);
        end
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_abort();
        test_mid_reset();
`ifdef SPI_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
